// File: rtl/cache_pkg.sv
// Shared constants and types for the L1 cache way arrays.
package cache_pkg;

  typedef enum logic {
    INIT,
    RUN
  } cache_state_e;

  localparam int unsigned CACHE_LINE_W = 151;
  localparam int unsigned CACHE_SETS   = 64;
  localparam int unsigned CACHE_WAYS   = 2;

endpackage : cache_pkg

// File: rtl/cache_way_bank.sv
// One way of the cache: simple dual-port RAM, registered read, no reset.
module cache_way_bank
  import cache_pkg::*;
#(
  parameter int unsigned SETS  = CACHE_SETS,
  parameter int unsigned WIDTH = CACHE_LINE_W,
  parameter int unsigned IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [SETS];
  logic [WIDTH-1:0] rdata_q;

  // Write port; contents are only defined once the owner has swept them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Enabled read register kept in the RAM process so it maps onto the
  // block RAM output register; it holds while re is low.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule : cache_way_bank

// File: rtl/cache_way_array.sv
// Multi-way cache storage: WAYS banks, post-reset clear sweep, masked
// writes and a write-first bypass on the registered read port.
module cache_way_array
  import cache_pkg::*;
#(
  parameter int unsigned WAYS  = CACHE_WAYS,
  parameter int unsigned SETS  = CACHE_SETS,
  parameter int unsigned WIDTH = CACHE_LINE_W,
  parameter int unsigned IDX_W = $clog2(SETS)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_index,
  output logic [WAYS*WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_index,
  input  logic [WAYS-1:0]       wr_way_mask,
  input  logic [WIDTH-1:0]      wr_data
);

  cache_state_e state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_zero_q, rd_zero_d;
  logic [WAYS-1:0]  byp_q, byp_d;
  logic [WIDTH-1:0] byp_data_q, byp_data_d;

  logic             init_sweep;
  logic             accept_rd;
  logic             accept_wr;
  logic [WAYS-1:0]  bank_we;
  logic [IDX_W-1:0] bank_waddr;
  logic [WIDTH-1:0] bank_wdata;
  logic [WIDTH-1:0] bank_rdata [WAYS];

  // State and clear counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state: sweep every set once, then run.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      INIT: begin
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
        if (clr_cnt_q == IDX_W'(SETS - 1)) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Outputs of the FSM: request acceptance and bank write steering.
  always_comb begin
    ready      = (state_q == RUN);
    init_sweep = (state_q == INIT) && !rst;
    accept_rd  = ready && rd_en && !rst;
    accept_wr  = ready && wr_en && !rst;
    bank_waddr = init_sweep ? clr_cnt_q : wr_index;
    bank_wdata = init_sweep ? '0 : wr_data;
    for (int unsigned w = 0; w < WAYS; w++) begin
      bank_we[w] = init_sweep || (accept_wr && wr_way_mask[w]);
    end
  end

  // Read-side bookkeeping: the banks return old data on a same-index
  // collision, so the bypass decision and write data are captured here and
  // applied on the output. rd_zero forces the post-reset zero result until
  // the first accepted read, since the bank read registers have no reset.
  always_comb begin
    rd_valid_d = accept_rd;
    rd_zero_d  = rd_zero_q && !accept_rd;
    byp_d      = byp_q;
    byp_data_d = byp_data_q;
    if (accept_rd) begin
      byp_d      = (accept_wr && (wr_index == rd_index)) ? wr_way_mask : '0;
      byp_data_d = wr_data;
    end
  end

  // Read-side registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_zero_q  <= rd_zero_d;
    end
  end

  // Bypass capture registers; only observed once rd_zero is clear.
  always_ff @(posedge clk) begin
    byp_q      <= byp_d;
    byp_data_q <= byp_data_d;
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way_bank #(
      .SETS  (SETS),
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .re    (accept_rd),
      .raddr (rd_index),
      .rdata (bank_rdata[g])
    );
  end

  // Output mux: zero after reset, else bypassed or stored line per way.
  always_comb begin
    rd_data = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!rd_zero_q) begin
        rd_data[w*WIDTH +: WIDTH] = byp_q[w] ? byp_data_q : bank_rdata[w];
      end
    end
  end

  assign rd_valid = rd_valid_q;

endmodule : cache_way_array

// File: doc/cache_way_array.md
# cache_way_array

Parametrised multi-way storage array for the L1 instruction and data caches. Holds WAYS independent ways of SETS lines, each WIDTH bits (tag, valid and data packed by the caller). Provides:
- one registered read port returning all ways at once;
- one write port with per-way write mask and write-first read bypass;
- a sequential clear engine that zeroes every line after reset, so the ways map onto block RAM with no per-cell reset.

## Interface

Parameters:
- WAYS, default 2: number of ways, at least 1.
- SETS, default 64: lines per way; power of two, at least 2.
- WIDTH, default 151: bits per line.
- IDX_W, default $clog2(SETS): index width; derived, never overridden.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst, input, 1: reset; synchronous, active-high.
- ready, output, 1: clear complete; requests are accepted only while high.
- rd_en, input, 1: read request.
- rd_index, input, IDX_W: read set index.
- rd_data, output, WAYS*WIDTH: way w occupies bits [w*WIDTH +: WIDTH].
- rd_valid, output, 1: pulses one cycle when rd_data carries the result of an accepted read.
- wr_en, input, 1: write request.
- wr_index, input, IDX_W: write set index.
- wr_way_mask, input, WAYS: ways to write; may be zero, one-hot or multi-hot.
- wr_data, input, WIDTH: line written to every masked way.

## Operation

States: INIT, RUN.

Reset:
- A rst edge sets state=INIT, clr_cnt=0, ready=0, rd_data=0 and rd_valid=0.
- rst takes priority over everything, including mid-INIT and mid-RUN. A mid-INIT reset restarts the clear at index 0.

INIT:
- Each non-reset edge writes all-zero to set clr_cnt in every way, then increments clr_cnt.
- On the edge that clears set SETS-1: state becomes RUN and ready=1.
- rd_en and wr_en are ignored. No array write from the port, rd_valid stays 0, rd_data stays 0.

RUN (reads and writes are independent and may occur in the same cycle):
- Write: when wr_en=1, each way w with wr_way_mask[w]=1 has wr_data written at wr_index. Unmasked ways are untouched.
- Read: when rd_en=1, all ways at rd_index are registered into rd_data, and rd_valid=1 on the next cycle.
- Bypass: if the read and write are in the same cycle with rd_index==wr_index, masked ways return the new wr_data (write-first). Unmasked ways return their stored contents.
- When rd_en=0, rd_data holds its last value and rd_valid=0.

Index range: indices are exactly IDX_W bits; there is no out-of-range case, and index SETS-1 is a normal set.

## Timing

- Clear latency: ready rises on the SETS-th rising edge with rst=0 after reset. Default SETS=64 gives 64 edges.
- Read latency: 1 cycle. Request at edge n; data and rd_valid are visible after edge n+1.
- Back-to-back reads at full rate: one result per cycle, in order.
- Write-to-read, different cycles: a read issued one or more cycles after a write sees the written data.
- Write-to-read, same cycle and same index: covered by the bypass above.
- The state, clr_cnt, ready and rd_valid registers reset synchronously.
- Array contents are not reset directly; they are defined only after the INIT sweep.

## Structure

- Shared package cache_pkg holds:
  - the state enum {INIT, RUN};
  - the default line width constant CACHE_LINE_W=151;
  - default SETS and WAYS constants, used by the icache and dcache tops.
- Sub-module cache_way_bank: one simple dual-port RAM of SETS×WIDTH with a registered read and no reset, instantiated WAYS times via generate.
- The top module holds the INIT counter and FSM, write-mask gating, the bypass comparators and muxes, and the rd_valid register.

## Test plan

- Clear duration: SETS=64, WAYS=2. Hold rst 3 cycles, release → ready=0 for 63 edges, then 1 on edge 64. Then read indices 0, 17 and 63 → rd_data=0, rd_valid=1 each.
- Masked write and readback: write 151'h5A5A…A5 to index 5 with mask 2'b01, then read 5 → way0=pattern, way1=0. Write 151'h1 to index 5 with mask 2'b10 → way0 unchanged, way1=1.
- Write-first bypass: in one cycle write 151'hDEAD to index 9 with mask 2'b11 and read index 9 → next cycle both ways=151'hDEAD. Repeat with mask 2'b01 → way1 keeps its old value.
- Requests during INIT: assert wr_en and rd_en at index 3 while ready=0 → rd_valid stays 0. After ready=1, a read of index 3 returns 0.
- Reset mid-operation: fill index 63 with data, then assert rst at clr_cnt=20 of a second INIT → ready stays 0 for 64 more edges after release. Then every index reads 0, including 63.
- Pipelined reads and wrap: with ready=1, issue reads of 62, 63, 0 and 1 on consecutive cycles → four consecutive rd_valid pulses with the matching stored data, in order.
